// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte handshake between uart_rx (master) and its consumer (slave)
// Signals: rx_data (byte), rx_valid (byte pending), rx_ready (consumer accepts on valid && ready)
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: idle-high LSB-first UART receiver with mid-bit sampling and a valid/ready byte output
// Ports: t_clk; reset (sync, active-high); rx_in (async serial line);
//   rx (uart_rx_if.master: rx_data/rx_valid out, rx_ready in); rx_busy (not IDLE);
//   frame_err / overrun / parity_err (one-cycle error pulses).
// Macro UART_RX_PARITY_EN: adds an even parity bit between data and stop; otherwise parity_err is 0.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic      t_clk,
  input  logic      reset,
  input  logic      rx_in,
  uart_rx_if.master rx,
  output logic      rx_busy,
  output logic      frame_err,
  output logic      overrun,
  output logic      parity_err
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;
`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic          rx_s;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          par_bad;
`ifdef UART_RX_PARITY_EN
  logic          par_q, par_d;
  logic          perr_q, perr_d;
  assign par_bad    = par_q;
  assign parity_err = perr_q;
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif
  assign rx_s        = sync_q[1];
  assign rx_busy     = state_q != IDLE;
  assign rx.rx_data  = data_q;
  assign rx.rx_valid = valid_q;
  assign frame_err   = ferr_q;
  assign overrun     = ovr_q;
  always_comb begin
    sync_d  = {sync_q[0], rx_in};
    state_d = state_q;
    tick_d  = tick_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q && !rx.rx_ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        tick_d  = '0;
        state_d = rx_s ? IDLE : START;
      end
      START: if (tick_q == T_HALF) begin
        tick_d  = '0;
        bit_d   = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (tick_q == T_FULL) begin
        tick_d  = '0;
        shift_d = {rx_s, shift_q[7:1]};
        bit_d   = bit_q + 1'b1;
        state_d = (bit_q == 3'd7) ? AFTER_DATA : DATA;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick_q == T_FULL) begin
        tick_d  = '0;
        par_d   = ^{shift_q, rx_s};
        state_d = STOP;
      end
`endif
      STOP: if (tick_q == T_FULL) begin
        tick_d  = '0;
        state_d = rx_s ? IDLE : WAIT_IDLE;
        ferr_d  = !rx_s;
`ifdef UART_RX_PARITY_EN
        perr_d  = rx_s && par_q;
`endif
        // A fresh byte may replace one that is being accepted in this very cycle.
        if (rx_s && !par_bad) begin
          if (!valid_q || rx.rx_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      // A held-low line (break) must return high before a new start is looked for.
      WAIT_IDLE: state_d = rx_s ? IDLE : WAIT_IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge t_clk) begin
    if (reset) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end
`ifdef UART_RX_PARITY_EN
  always_ff @(posedge t_clk) begin
    if (reset) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end
`endif
endmodule
